// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams in, one shared serializer byte stream out, plus grant/overrun status.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [N_REQ-1:0]   grant;
  logic               pkt_overrun;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, pkt_overrun
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, pkt_overrun
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART serializer; grant one cycle after request.
// Owner bytes pass through combinationally; owner req_ready mirrors tx_ready, others held off.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int MAX_PKT = 64
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [8:0] MAX_CNT = 9'(MAX_PKT);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic              pkt_overrun_q, pkt_overrun_d;

  logic              any_req;
  logic [IDX_W-1:0]  sel;
  logic [CW-1:0]     cand;
  logic              cur_valid;
  logic              cur_last;
  logic [7:0]        cur_data;
  logic              xfer;
  logic              cnt_full;

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    any_req = 1'b0;
    sel     = rr_ptr_q;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (bus.req_valid[cand[IDX_W-1:0]]) begin
        any_req = 1'b1;
        sel     = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    cur_valid = bus.req_valid[owner_q];
    cur_last  = bus.req_last[owner_q];
    cur_data  = bus.req_data[{owner_q, 3'b000} +: 8];
    cnt_full  = (({1'b0, byte_cnt_q} + 9'd1) == MAX_CNT);
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    byte_cnt_d     = byte_cnt_q;
    pkt_overrun_d  = 1'b0;
    xfer           = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = N_REQ'(1) << sel;
          owner_d    = sel;
          byte_cnt_d = 8'd0;
          state_d    = LOCK;
        end
      end

      LOCK: begin
        bus.tx_valid  = cur_valid;
        bus.tx_data   = cur_data;
        bus.req_ready = grant_q & {N_REQ{bus.tx_ready}};
        xfer          = cur_valid & bus.tx_ready;
        if (xfer) begin
          if (cur_last || cnt_full) begin
            // Overrun only flags a forced release; a last byte at the limit is a clean end.
            pkt_overrun_d = ~cur_last;
            state_d       = IDLE;
            grant_d       = '0;
            byte_cnt_d    = 8'd0;
            rr_ptr_d      = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      byte_cnt_q    <= 8'd0;
      pkt_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      pkt_overrun_q <= pkt_overrun_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.pkt_overrun = pkt_overrun_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed bytes, a monitor scores every tx byte.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 2;
  localparam int MAX_PKT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .MAX_PKT(MAX_PKT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] src;
    logic [7:0] dat;
  } exp_t;

  exp_t             exp_q[$];
  logic [8:0]       src_q[N_REQ][$];
  logic [N_REQ-1:0] acc = '0;
  int               checks   = 0;
  int               failures = 0;
  int               ovr_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard side: every serializer handshake must match the next expected byte and owner.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= bus.req_valid & bus.req_ready;
      if (bus.pkt_overrun) ovr_cnt <= ovr_cnt + 1;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h, required no transfer", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(e.dat));
          chk("tx_owner", 32'(bus.grant), 32'(1) << e.src);
        end
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*8 +: 8]  = src_q[i][0][7:0];
        bus.req_last[i]         = src_q[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*8 +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    refresh();
  endtask

  task automatic put_src(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic put_exp(input int r, input logic [7:0] d);
    exp_q.push_back({3'(r), d});
  endtask

  function automatic bit busy();
    return (exp_q.size() != 0) || (src_q[0].size() != 0) || (src_q[1].size() != 0);
  endfunction

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_grant"},    32'(bus.grant),       32'd0);
    chk({name, "_tx_valid"}, 32'(bus.tx_valid),    32'd0);
    chk({name, "_req_ready"},32'(bus.req_ready),   32'd0);
    chk({name, "_overrun"},  32'(bus.pkt_overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ovr0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
    rst           = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_idle_outputs("reset");
    tick();
    rst = 1'b0;

    // Single 3-byte packet from requester 0
    tick();
    put_src(0, 8'h41, 1'b0); put_src(0, 8'h42, 1'b0); put_src(0, 8'h43, 1'b1);
    put_exp(0, 8'h41); put_exp(0, 8'h42); put_exp(0, 8'h43);
    refresh();
    @(negedge clk);
    chk("t1_idle_grant", 32'(bus.grant), 32'd0);
    chk("t1_idle_tx_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_grant", 32'(bus.grant), 32'd1);
    chk("t1_tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("t1_first_byte", 32'(bus.tx_data), 32'h41);
    drain(20, "t1");
    chk("t1_released_grant", 32'(bus.grant), 32'd0);

    // Round-robin fairness from reset: expected owner order 0,1,0,1
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    put_src(0, 8'h10, 1'b0); put_src(0, 8'h11, 1'b1); put_src(0, 8'h12, 1'b1);
    put_src(1, 8'h20, 1'b0); put_src(1, 8'h21, 1'b1); put_src(1, 8'h22, 1'b1);
    put_exp(0, 8'h10); put_exp(0, 8'h11);
    put_exp(1, 8'h20); put_exp(1, 8'h21);
    put_exp(0, 8'h12);
    put_exp(1, 8'h22);
    refresh();
    drain(40, "t2");

    // tx_ready toggling; last byte coincides with MAX_PKT so no overrun
    tick();
    ovr0 = ovr_cnt;
    bus.tx_ready = 1'b0;
    put_src(0, 8'h51, 1'b0); put_src(0, 8'h52, 1'b0);
    put_src(0, 8'h53, 1'b0); put_src(0, 8'h54, 1'b1);
    put_exp(0, 8'h51); put_exp(0, 8'h52); put_exp(0, 8'h53); put_exp(0, 8'h54);
    refresh();
    n = 0;
    while (busy() && n < 40) begin
      tick();
      bus.tx_ready = ~bus.tx_ready;
      @(negedge clk);
      if (bus.grant == 2'b01) chk("t3_req_ready", 32'(bus.req_ready), {31'd0, bus.tx_ready});
      n++;
    end
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    chk("t3_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // Forced release after MAX_PKT bytes; pending requester 0 wins next
    ovr0 = ovr_cnt;
    for (int b = 0; b < 6; b++) put_src(1, 8'h61 + 8'(b), 1'b0);
    put_src(1, 8'h67, 1'b1);
    put_src(0, 8'h71, 1'b1);
    for (int b = 0; b < 4; b++) put_exp(1, 8'h61 + 8'(b));
    put_exp(0, 8'h71);
    put_exp(1, 8'h65); put_exp(1, 8'h66); put_exp(1, 8'h67);
    refresh();
    drain(60, "t4");
    tick();
    tick();
    chk("t4_overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);

    // Owner goes quiet mid-packet while requester 1 waits
    put_src(0, 8'h81, 1'b0); put_src(0, 8'h82, 1'b0);
    put_src(1, 8'h91, 1'b1);
    put_exp(0, 8'h81); put_exp(0, 8'h82); put_exp(0, 8'h83); put_exp(1, 8'h91);
    refresh();
    n = 0;
    while (src_q[0].size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("t5_owner_drained", 32'(src_q[0].size()), 32'd0);
    repeat (10) begin
      tick();
      @(negedge clk);
      chk("t5_hold_grant", 32'(bus.grant), 32'd1);
      chk("t5_hold_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("t5_hold_req1_ready", 32'(bus.req_ready[1]), 32'd0);
    end
    tick();
    put_src(0, 8'h83, 1'b1);
    refresh();
    drain(30, "t5");

    // Move rr_ptr to 1, then reset mid-packet and expect arbitration from 0 again
    tick();
    put_src(0, 8'hC1, 1'b1);
    put_exp(0, 8'hC1);
    refresh();
    drain(20, "t6a");
    tick();
    put_src(1, 8'hD1, 1'b0); put_src(1, 8'hD2, 1'b0);
    put_src(1, 8'hD3, 1'b0); put_src(1, 8'hD4, 1'b1);
    put_src(0, 8'hE1, 1'b1);
    put_exp(1, 8'hD1); put_exp(1, 8'hD2);
    refresh();
    n = 0;
    while (src_q[1].size() != 2 && n < 30) begin
      tick();
      n++;
    end
    chk("t6_pre_reset", 32'(src_q[1].size()), 32'd2);
    bus.tx_ready = 1'b0;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t6_after_rst");
    put_exp(0, 8'hE1); put_exp(1, 8'hD3); put_exp(1, 8'hD4);
    drain(40, "t6");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
